tone_synth: RTL and testbench

- Keyboard-to-audio stage that turns the 16 note switches and the current octave band into a square-wave drive for the bell/buzzer pin.
- Sits directly downstream of the band selector (left/right octave control) and upstream of the bell output.
- Also exports the sounding note index and a gate flag for the LED and 7-segment display path.
- Adds a release tail: the tone keeps sounding for a programmable time after all keys are let go.

---
 rtl/tone_synth.sv | 159 +++++++++++++++
 tb/tb_tone_synth.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_synth.sv
// Turns the note switches and octave band into a square-wave bell drive, with a release tail.
// Latency: 1 cycle input register, then 1 cycle to state change; first toggle lands half cycles after cnt restarts.
// Backpressure: none; key/band are level inputs and are sampled every cycle.
module tone_synth #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REL_CYCLES = 10_000_000,
    parameter int SIM_SHIFT  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key,
    input  logic [2:0]  band,
    output logic        bell,
    output logic        gate,
    output logic [3:0]  note_idx,
    output logic [15:0] led
);

    localparam int REL_W = (REL_CYCLES > 1) ? $clog2(REL_CYCLES) : 1;
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(REL_CYCLES - 1);

    // Half-period table for the C2 octave, computed for CLK_HZ = 100 MHz.
    if (REL_CYCLES < 1 || CLK_HZ < 1) begin : g_param_check
        $error("tone_synth: REL_CYCLES and CLK_HZ must be positive");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state;
    logic [15:0]      key_q;
    logic [2:0]       band_q;
    logic [19:0]      cnt;
    logic [REL_W-1:0] rel_cnt;

    logic             any_key;
    logic [3:0]       sel_idx;
    logic [3:0]       semi;
    logic             oct;
    logic [5:0]       shamt;
    logic [19:0]      half_raw;
    logic [19:0]      half;
    logic             tone_tc;
    logic             rel_done;
    logic             note_chg;

    function automatic logic [19:0] base_of(input logic [3:0] s);
        logic [19:0] b;
        case (s)
            4'd0:    b = 20'd764451;
            4'd1:    b = 20'd721546;
            4'd2:    b = 20'd681048;
            4'd3:    b = 20'd642824;
            4'd4:    b = 20'd606745;
            4'd5:    b = 20'd572691;
            4'd6:    b = 20'd540548;
            4'd7:    b = 20'd510210;
            4'd8:    b = 20'd481574;
            4'd9:    b = 20'd454545;
            4'd10:   b = 20'd429033;
            4'd11:   b = 20'd404954;
            default: b = 20'd764451;
        endcase
        return b;
    endfunction

    // Highest set key wins.
    always_comb begin
        sel_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (key_q[i]) begin
                sel_idx = 4'(i);
            end
        end
    end

    assign any_key  = |key_q;
    assign note_chg = any_key && (sel_idx != note_idx);

    assign oct      = (note_idx >= 4'd12);
    assign semi     = oct ? (note_idx - 4'd12) : note_idx;
    assign shamt    = 6'(band_q) + 6'(oct) + 6'(SIM_SHIFT);
    assign half_raw = base_of(semi) >> shamt;
    assign half     = (half_raw == 20'd0) ? 20'd1 : half_raw;

    // ">=" rather than "==" so a band change to a shorter period toggles at once instead of wrapping.
    assign tone_tc  = (cnt >= (half - 20'd1));
    assign rel_done = (rel_cnt == REL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q    <= 16'd0;
            band_q   <= 3'd0;
            state    <= IDLE;
            cnt      <= 20'd0;
            rel_cnt  <= '0;
            bell     <= 1'b0;
            gate     <= 1'b0;
            note_idx <= 4'd0;
            led      <= 16'd0;
        end else begin
            key_q  <= key;
            band_q <= band;
            case (state)
                IDLE: begin
                    bell <= 1'b0;
                    cnt  <= 20'd0;
                    if (any_key) begin
                        state    <= PLAY;
                        note_idx <= sel_idx;
                        gate     <= 1'b1;
                        led      <= 16'd1 << sel_idx;
                    end
                end
                PLAY, RELEASE: begin
                    if (state == RELEASE && !any_key && rel_done) begin
                        state <= IDLE;
                        bell  <= 1'b0;
                        cnt   <= 20'd0;
                        gate  <= 1'b0;
                        led   <= 16'd0;
                    end else begin
                        if (any_key) begin
                            state <= PLAY;
                        end else if (state == PLAY) begin
                            state   <= RELEASE;
                            rel_cnt <= '0;
                        end else begin
                            rel_cnt <= rel_cnt + REL_W'(1);
                        end

                        // A note change restarts the period and suppresses a coincident toggle.
                        if (note_chg) begin
                            note_idx <= sel_idx;
                            led      <= 16'd1 << sel_idx;
                            cnt      <= 20'd0;
                        end else if (tone_tc) begin
                            bell <= ~bell;
                            cnt  <= 20'd0;
                        end else begin
                            cnt <= cnt + 20'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    bell  <= 1'b0;
                    cnt   <= 20'd0;
                    gate  <= 1'b0;
                    led   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth with SIM_SHIFT=8 and a 50-cycle release tail.
module tb_tone_synth;

    logic        clk;
    logic        rst;
    logic [15:0] key;
    logic [2:0]  band;
    logic        bell;
    logic        gate;
    logic [3:0]  note_idx;
    logic [15:0] led;

    int compared;
    int mismatched;

    tone_synth #(
        .CLK_HZ    (100_000_000),
        .REL_CYCLES(50),
        .SIM_SHIFT (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key     (key),
        .band    (band),
        .bell    (bell),
        .gate    (gate),
        .note_idx(note_idx),
        .led     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        key  = 16'd0;
        band = 3'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Steps until gate is high; n = -1 on timeout.
    task automatic wait_gate(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (gate === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Steps until bell changes level; n = -1 on timeout.
    task automatic wait_toggle(output int n);
        logic prev;
        prev = bell;
        n = -1;
        for (int i = 1; i <= 5000; i++) begin
            step();
            if (bell !== prev) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        key  = 16'hFFFF;
        band = 3'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++;
            if ({bell, gate, note_idx, led} !== 22'd0) begin
                mismatched++;
                $display("FAIL reset_hold[%0d]: bell=%b gate=%b note=%0d led=%h required all zero",
                         i, bell, gate, note_idx, led);
            end
        end
        rst = 1'b0;
        step();
        compared++;
        if (gate !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_gate_1cyc: got %b required 0", gate);
        end
        step();
        compared++;
        if (gate !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_gate_2cyc: got %b required 1", gate);
        end
        compared++;
        if (note_idx !== 4'd15) begin
            mismatched++;
            $display("FAIL reset_note: got %0d required 15", note_idx);
        end
        compared++;
        if (led !== 16'h8000) begin
            mismatched++;
            $display("FAIL reset_led: got %h required 8000", led);
        end
    endtask

    task automatic test_period();
        int n;
        do_reset();
        key = 16'd1 << 9;
        wait_gate(n);
        compared++;
        if (n !== 2) begin
            mismatched++;
            $display("FAIL period_gate_latency: got %0d required 2", n);
        end
        wait_toggle(n);
        compared++;
        if (n !== 1775) begin
            mismatched++;
            $display("FAIL period_a_first: got %0d required 1775", n);
        end
        wait_toggle(n);
        compared++;
        if (n !== 1775) begin
            mismatched++;
            $display("FAIL period_a_second: got %0d required 1775", n);
        end
        band = 3'd1;
        wait_toggle(n);
        compared++;
        if (n !== 887) begin
            mismatched++;
            $display("FAIL period_band1_first: got %0d required 887", n);
        end
        wait_toggle(n);
        compared++;
        if (n !== 887) begin
            mismatched++;
            $display("FAIL period_band1_second: got %0d required 887", n);
        end
        band = 3'd0;
        wait_toggle(n);
        compared++;
        if (n !== 1775) begin
            mismatched++;
            $display("FAIL period_band0_again: got %0d required 1775", n);
        end
        // cnt runs past the new terminal count, so the toggle comes right after band_q updates.
        for (int i = 0; i < 1000; i++) step();
        band = 3'd1;
        wait_toggle(n);
        compared++;
        if (n !== 2) begin
            mismatched++;
            $display("FAIL period_band_shrink: got %0d required 2", n);
        end
        wait_toggle(n);
        compared++;
        if (n !== 887) begin
            mismatched++;
            $display("FAIL period_after_shrink: got %0d required 887", n);
        end
    endtask

    task automatic test_priority();
        int n;
        do_reset();
        key = (16'd1 << 3) | (16'd1 << 14);
        wait_gate(n);
        compared++;
        if (note_idx !== 4'd14) begin
            mismatched++;
            $display("FAIL prio_note: got %0d required 14", note_idx);
        end
        compared++;
        if (led !== 16'h4000) begin
            mismatched++;
            $display("FAIL prio_led: got %h required 4000", led);
        end
        wait_toggle(n);
        compared++;
        if (n !== 1330) begin
            mismatched++;
            $display("FAIL prio_half14: got %0d required 1330", n);
        end
        key = 16'd1 << 3;
        step();
        compared++;
        if (note_idx !== 4'd14) begin
            mismatched++;
            $display("FAIL prio_note_1edge: got %0d required 14", note_idx);
        end
        step();
        compared++;
        if (note_idx !== 4'd3) begin
            mismatched++;
            $display("FAIL prio_note_2edge: got %0d required 3", note_idx);
        end
        compared++;
        if (bell !== 1'b1) begin
            mismatched++;
            $display("FAIL prio_bell_held: got %b required 1", bell);
        end
        compared++;
        if (led !== 16'h0008) begin
            mismatched++;
            $display("FAIL prio_led_new: got %h required 0008", led);
        end
        wait_toggle(n);
        compared++;
        if (n !== 2511) begin
            mismatched++;
            $display("FAIL prio_cnt_restart: got %0d required 2511", n);
        end
    endtask

    task automatic test_octave();
        int n;
        do_reset();
        key = 16'd1 << 12;
        wait_gate(n);
        wait_toggle(n);
        compared++;
        if (n !== 1493) begin
            mismatched++;
            $display("FAIL octave_first: got %0d required 1493", n);
        end
        wait_toggle(n);
        compared++;
        if (n !== 1493) begin
            mismatched++;
            $display("FAIL octave_second: got %0d required 1493", n);
        end
        compared++;
        if (note_idx !== 4'd12) begin
            mismatched++;
            $display("FAIL octave_note: got %0d required 12", note_idx);
        end
    endtask

    task automatic test_release();
        int   n;
        int   fall;
        int   toggles;
        logic prev;
        do_reset();
        band = 3'd7;
        key  = 16'd1 << 15;
        wait_gate(n);
        for (int i = 0; i < 20; i++) step();
        key     = 16'd0;
        fall    = 0;
        toggles = 0;
        prev    = bell;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (gate !== 1'b1 && fall == 0) fall = k;
            if (fall == 0 && bell !== prev) toggles++;
            prev = bell;
        end
        compared++;
        if (fall !== 52) begin
            mismatched++;
            $display("FAIL release_gate_fall: got step %0d required 52", fall);
        end
        compared++;
        if (toggles < 4) begin
            mismatched++;
            $display("FAIL release_tone_continues: got %0d toggles required at least 4", toggles);
        end
        compared++;
        if ({bell, gate, led} !== 18'd0) begin
            mismatched++;
            $display("FAIL release_idle_out: bell=%b gate=%b led=%h required all zero", bell, gate, led);
        end
        compared++;
        if (note_idx !== 4'd15) begin
            mismatched++;
            $display("FAIL release_note_hold: got %0d required 15", note_idx);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        key = 16'd1 << 15;
        wait_gate(n);
        for (int i = 0; i < 20; i++) step();
        key = 16'd0;
        for (int k = 1; k <= 50; k++) step();
        key = 16'd1 << 15;
        step();
        compared++;
        if (gate !== 1'b1) begin
            mismatched++;
            $display("FAIL repress_step51: got %b required 1", gate);
        end
        step();
        compared++;
        if (gate !== 1'b1) begin
            mismatched++;
            $display("FAIL repress_expiry_edge: got %b required 1", gate);
        end
        for (int i = 0; i < 60; i++) step();
        compared++;
        if (gate !== 1'b1) begin
            mismatched++;
            $display("FAIL repress_stays_play: got %b required 1", gate);
        end
        // One cycle later the release has already expired.
        key = 16'd0;
        for (int k = 1; k <= 51; k++) step();
        key = 16'd1 << 15;
        step();
        compared++;
        if (gate !== 1'b0) begin
            mismatched++;
            $display("FAIL late_press_expired: got %b required 0", gate);
        end
        step();
        compared++;
        if (gate !== 1'b1) begin
            mismatched++;
            $display("FAIL late_press_replay: got %b required 1", gate);
        end
    endtask

    task automatic test_reset_midtone();
        int n;
        do_reset();
        band = 3'd7;
        key  = 16'd1 << 15;
        wait_gate(n);
        wait_toggle(n);
        compared++;
        if (bell !== 1'b1) begin
            mismatched++;
            $display("FAIL midrst_bell_high: got %b required 1", bell);
        end
        rst = 1'b1;
        step();
        compared++;
        if ({bell, gate, note_idx, led} !== 22'd0) begin
            mismatched++;
            $display("FAIL midrst_outputs: bell=%b gate=%b note=%0d led=%h required all zero",
                     bell, gate, note_idx, led);
        end
        rst = 1'b0;
        wait_gate(n);
        compared++;
        if (n !== 2) begin
            mismatched++;
            $display("FAIL midrst_gate_latency: got %0d required 2", n);
        end
        wait_toggle(n);
        compared++;
        if (n !== 9) begin
            mismatched++;
            $display("FAIL midrst_first_toggle: got %0d required 9", n);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst  = 1'b1;
        key  = 16'hFFFF;
        band = 3'd0;
        test_reset();
        test_period();
        test_priority();
        test_octave();
        test_release();
        test_back_to_back();
        test_reset_midtone();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
